// File: rtl/booth_pkg.sv
// Shared types and helpers for the signed sequential divider.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned CNT_W = $clog2(DEF_N + 1);

  // Counter width for an arbitrary operand width n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Magnitude of the low w bits of v taken as a signed value; 2^(w-1) stays representable.
  function automatic logic [31:0] abs_n(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    if (v[w-1])
      return (~v + 32'h1) & mask;
    else
      return v & mask;
  endfunction

endpackage

// File: rtl/booth_divider_div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N:0]   pr,
  input  logic [N-1:0] qsh,
  input  logic [N-1:0] mag_b,
  output logic [N:0]   pr_nx,
  output logic [N-1:0] qsh_nx
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // One extra bit of headroom lets the trial sign be read directly.
  always_comb begin
    shifted = {pr, qsh[N-1]};
    trial   = shifted - {2'b00, mag_b};
    if (!trial[N+1]) begin
      pr_nx  = trial[N:0];
      qsh_nx = {qsh[N-2:0], 1'b1};
    end else begin
      pr_nx  = shifted[N:0];
      qsh_nx = {qsh[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring loop on magnitudes, then sign fix-up.
module booth_divider
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  div_state_t   state;
  logic [CW-1:0] cnt;
  logic [N:0]   pr;
  logic [N-1:0] qsh;
  logic [N-1:0] mag_b;
  logic         sign_q;
  logic         sign_r;
  logic         ovf_case;

  logic [N:0]   pr_nx;
  logic [N-1:0] qsh_nx;
  logic [N-1:0] mag_a_in;
  logic [N-1:0] mag_b_in;

  assign mag_a_in = N'(abs_n(32'(A), N));
  assign mag_b_in = N'(abs_n(32'(B), N));

  div_step #(.N(N)) u_step (
    .pr     (pr),
    .qsh    (qsh),
    .mag_b  (mag_b),
    .pr_nx  (pr_nx),
    .qsh_nx (qsh_nx)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      qsh         <= '0;
      mag_b       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_case    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_q   <= A[N-1] ^ B[N-1];
            sign_r   <= A[N-1];
            qsh      <= mag_a_in;
            mag_b    <= mag_b_in;
            pr       <= '0;
            cnt      <= '0;
            // Operands may change after acceptance, so the overflow case is latched now.
            ovf_case <= (A == MIN_VAL) && (B == '1);
            if (B == '0) begin
              quotient    <= '1;
              remainder   <= A;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              state       <= DONE;
            end else begin
              state <= ITER;
            end
          end
        end
        ITER: begin
          pr  <= pr_nx;
          qsh <= qsh_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1))
            state <= FIX;
        end
        FIX: begin
          quotient    <= sign_q ? -qsh : qsh;
          remainder   <= sign_r ? -pr[N-1:0] : pr[N-1:0];
          overflow    <= ovf_case;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed and randomized checks of booth_divider against a truncating-division model.
module tb_booth_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_chk = 0;
  int n_err = 0;

  booth_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic with the defined special cases.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r,
                       output logic dz, output logic ov, output int lat);
    int sa, sb, iq, ir;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    lat = N + 2;
    if (sb == 0) begin
      iq = -1; ir = sa; dz = 1'b1; lat = 1;
    end else if (sa == -(1 << (N - 1)) && sb == -1) begin
      iq = sa; ir = 0; ov = 1'b1;
    end else begin
      iq = sa / sb; ir = sa % sb;
    end
    q = N'(iq);
    r = N'(ir);
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit full);
    logic [N-1:0] eq, er;
    logic edz, eov;
    int elat, cyc;
    model(a, b, eq, er, edz, eov, elat);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = N'($urandom); B = N'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      if (full) chk("busy_during_op", 32'(busy), 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (full) begin
      chk("latency", 32'(cyc), 32'(elat));
      chk("busy_at_done", 32'(busy), 32'd1);
    end
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(edz));
    chk("overflow", 32'(overflow), 32'(eov));
    @(negedge clk);
    if (full) begin
      chk("done_pulse_ends", 32'(done), 32'd0);
      chk("idle_after", 32'(busy), 32'd0);
      chk("quotient_held", 32'(quotient), 32'(eq));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(4'b0111, 4'b0010, 1'b1);
    run_op(4'b1001, 4'b0010, 1'b1);
    run_op(4'b0111, 4'b1110, 1'b1);
    run_op(4'b1000, 4'b1111, 1'b1);
    run_op(4'b1000, 4'b0001, 1'b1);
    run_op(4'b0101, 4'b0000, 1'b1);

    // Abort: second start during ITER ignored, reset lands on edge 3.
    A = 4'b0111; B = 4'b0010; start = 1'b1;
    @(negedge clk);
    chk("abort_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("abort_no_done_c2", 32'(done), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_op(4'b0110, 4'b0011, 1'b1);

    // Start asserted during the DONE cycle is ignored.
    A = 4'b0111; B = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n_chk < 100000) @(negedge clk);
    start = 1'b1; A = 4'b0011; B = 4'b0001;
    @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);

    for (int unsigned a = 0; a < 16; a++)
      for (int unsigned b = 0; b < 16; b++)
        run_op(N'(a), N'(b), 1'b0);

    for (int unsigned i = 0; i < 100; i++)
      run_op(N'($urandom), N'($urandom), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
